// File: rtl/divider_cir_if.sv
// Operand/result bundle for divider_cir.
// Optional macro DIV_ZERO_FLAG_EN adds the div_zero result flag.
interface divider_cir_if #(
    parameter int unsigned WIDTH = 8
);
    logic             ready;
    logic [WIDTH-1:0] Divisor;
    logic [WIDTH-1:0] Dividend;
    logic [WIDTH-1:0] Quotient;
    logic [WIDTH-1:0] Reminder;
    logic             done;
`ifdef DIV_ZERO_FLAG_EN
    logic             div_zero;
`endif

`ifdef DIV_ZERO_FLAG_EN
    modport master (
        output ready, Divisor, Dividend,
        input  Quotient, Reminder, done, div_zero
    );
    modport slave (
        input  ready, Divisor, Dividend,
        output Quotient, Reminder, done, div_zero
    );
`else
    modport master (
        output ready, Divisor, Dividend,
        input  Quotient, Reminder, done
    );
    modport slave (
        input  ready, Divisor, Dividend,
        output Quotient, Reminder, done
    );
`endif
endinterface

// File: rtl/divider_cir.sv
// Sequential restoring unsigned divider: one quotient bit per clock, WIDTH cycles per result.
// Optional macro DIV_ZERO_FLAG_EN adds a registered div_zero flag that updates with done.
module divider_cir #(
    parameter int unsigned WIDTH = 8
) (
    input logic            clk,
    input logic            rst_n,
    divider_cir_if.slave   bus
);
    localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [0:0] {StIdle, StBusy} state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]  rem_q, rem_d;
    logic [WIDTH-1:0]  quo_q, quo_d;
    logic [WIDTH-1:0]  div_q, div_d;
    logic [WIDTH-1:0]  quotient_q, quotient_d;
    logic [WIDTH-1:0]  reminder_q, reminder_d;
    logic              done_q, done_d;
`ifdef DIV_ZERO_FLAG_EN
    logic              dz_q, dz_d;
`endif

    logic [WIDTH:0]    rem_shift;
    logic [WIDTH-1:0]  quo_shift;
    logic              rem_ge;
    logic [WIDTH-1:0]  rem_next;
    logic [WIDTH-1:0]  quo_next;

    // One restoring step; the subtraction result always fits in WIDTH bits when taken.
    always_comb begin
        rem_shift = {rem_q, quo_q[WIDTH-1]};
        quo_shift = {quo_q[WIDTH-2:0], 1'b0};
        rem_ge    = (rem_shift >= {1'b0, div_q});
        rem_next  = rem_ge ? (rem_shift[WIDTH-1:0] - div_q) : rem_shift[WIDTH-1:0];
        quo_next  = {quo_shift[WIDTH-1:1], rem_ge};
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rem_d      = rem_q;
        quo_d      = quo_q;
        div_d      = div_q;
        quotient_d = quotient_q;
        reminder_d = reminder_q;
        done_d     = 1'b0;
`ifdef DIV_ZERO_FLAG_EN
        dz_d       = dz_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (bus.ready) begin
                    state_d = StBusy;
                    div_d   = bus.Divisor;
                    quo_d   = bus.Dividend;
                    rem_d   = '0;
                    cnt_d   = CntW'(WIDTH - 1);
                end
            end
            StBusy: begin
                rem_d = rem_next;
                quo_d = quo_next;
                cnt_d = cnt_q - CntW'(1);
                if (cnt_q == '0) begin
                    state_d    = StIdle;
                    quotient_d = quo_next;
                    reminder_d = rem_next;
                    done_d     = 1'b1;
`ifdef DIV_ZERO_FLAG_EN
                    dz_d       = (div_q == '0);
`endif
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            rem_q      <= '0;
            quo_q      <= '0;
            div_q      <= '0;
            quotient_q <= '0;
            reminder_q <= '0;
            done_q     <= 1'b0;
`ifdef DIV_ZERO_FLAG_EN
            dz_q       <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rem_q      <= rem_d;
            quo_q      <= quo_d;
            div_q      <= div_d;
            quotient_q <= quotient_d;
            reminder_q <= reminder_d;
            done_q     <= done_d;
`ifdef DIV_ZERO_FLAG_EN
            dz_q       <= dz_d;
`endif
        end
    end

    assign bus.Quotient = quotient_q;
    assign bus.Reminder = reminder_q;
    assign bus.done     = done_q;
`ifdef DIV_ZERO_FLAG_EN
    assign bus.div_zero = dz_q;
`endif

endmodule

// File: tb/tb_divider_cir.sv
// Scoreboard bench for divider_cir: stimulus pushes hand-computed results, a monitor checks them.
module tb_divider_cir;
    localparam int unsigned W = 8;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dz;
        int           cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    divider_cir_if #(.WIDTH(W)) bus ();

    divider_cir #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: inputs change #1 after posedge, so both rst_n at the edge and outputs at
    // the following negedge are stable.
    initial begin : monitor
        logic         rst_at_edge;
        logic [W-1:0] held_q;
        logic [W-1:0] held_r;
        exp_t         e;
        held_q = '0;
        held_r = '0;
        forever begin
            @(posedge clk);
            cyc++;
            rst_at_edge = rst_n;
            @(negedge clk);
            if (!rst_at_edge) begin
                held_q = '0;
                held_r = '0;
                sb.delete();
                check("reset_quotient", int'(bus.Quotient), 0);
                check("reset_reminder", int'(bus.Reminder), 0);
                check("reset_done", int'(bus.done), 0);
            end else if (bus.done === 1'b1) begin
                if (sb.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    e = sb.pop_front();
                    check("quotient", int'(bus.Quotient), int'(e.q));
                    check("reminder", int'(bus.Reminder), int'(e.r));
                    check("latency", cyc, e.cyc);
`ifdef DIV_ZERO_FLAG_EN
                    check("div_zero", int'(bus.div_zero), int'(e.dz));
`endif
                    held_q = e.q;
                    held_r = e.r;
                end
            end else begin
                check("hold_quotient", int'(bus.Quotient), int'(held_q));
                check("hold_reminder", int'(bus.Reminder), int'(held_r));
                check("done_low", int'(bus.done), 0);
            end
        end
    end

    // Issue one start strobe; accepted at the next edge, result expected W edges later.
    task automatic start_div(input logic [W-1:0] dividend, input logic [W-1:0] divisor,
                             input logic [W-1:0] q, input logic [W-1:0] r);
        exp_t e;
        bus.Dividend = dividend;
        bus.Divisor  = divisor;
        bus.ready    = 1'b1;
        e.q   = q;
        e.r   = r;
        e.dz  = (divisor == '0);
        e.cyc = cyc + 1 + int'(W);
        sb.push_back(e);
        @(posedge clk);
        #1 bus.ready = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && sb.size() != 0; i++) @(posedge clk);
        if (sb.size() != 0) begin
            check("drain_timeout", sb.size(), 0);
            sb.delete();
        end
        @(posedge clk);
        #1;
    endtask

    initial begin : stim
        exp_t e;
        rst_n        = 1'b0;
        bus.ready    = 1'b0;
        bus.Dividend = '0;
        bus.Divisor  = '0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        start_div(8'd133, 8'd17, 8'd7, 8'd14);
        drain();
        repeat (3) @(posedge clk);
        #1;

        start_div(8'd255, 8'd1, 8'd255, 8'd0);
        drain();
        start_div(8'd5, 8'd9, 8'd0, 8'd5);
        drain();
        start_div(8'd100, 8'd0, 8'd255, 8'd100);
        drain();

        // Ready toggling and operand changes while busy must be ignored.
        start_div(8'd200, 8'd7, 8'd28, 8'd4);
        for (int i = 0; i < 6; i++) begin
            bus.ready    = (i % 2 == 0);
            bus.Dividend = 8'(13 * i + 3);
            bus.Divisor  = 8'(i + 2);
            @(posedge clk);
            #1;
        end
        bus.ready = 1'b0;
        drain();

        // Held ready: second division starts on the edge right after completion.
        bus.Dividend = 8'd60;
        bus.Divisor  = 8'd7;
        bus.ready    = 1'b1;
        e.q = 8'd8; e.r = 8'd4; e.dz = 1'b0; e.cyc = cyc + 1 + int'(W);
        sb.push_back(e);
        @(posedge clk);
        #1;
        bus.Dividend = 8'd9;
        bus.Divisor  = 8'd3;
        e.q = 8'd3; e.r = 8'd0; e.dz = 1'b0; e.cyc = cyc + int'(W) + 1 + int'(W);
        sb.push_back(e);
        repeat (W + 1) @(posedge clk);
        #1 bus.ready = 1'b0;
        drain();

        // Reset at the 4th busy edge aborts without a done pulse.
        start_div(8'd133, 8'd17, 8'd7, 8'd14);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (W + 3) @(posedge clk);
        #1;
        start_div(8'd50, 8'd6, 8'd8, 8'd2);
        drain();
        repeat (3) @(posedge clk);
        #1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation still running at time %0t, expected finish", $time);
        $fatal(1);
    end

endmodule
